// File: rtl/serial_rx_package.sv
`default_nettype none
// ============================================================================
// Module   : serial_rx_package
// Purpose  : 8N1 serial receiver packing 2**AddressWidth words into one package.
//            Optional macro SERIAL_RX_PACKAGE_TIMEOUT_EN discards stale partials.
// Revision : 1.0 - initial release
// ============================================================================
module serial_rx_package #(
  parameter int AddressWidth     = 2,
  parameter int WordWidth        = 8,
  parameter int SerialTimerWidth = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   rx,
  output logic [(2**AddressWidth)*WordWidth-1:0] data,
  output logic                                   valid,
  output logic                                   error,
  output logic                                   busy
);

  localparam int PKG_W = (2**AddressWidth) * WordWidth;
  localparam int IDX_W = $clog2(WordWidth + 1);

  localparam logic [SerialTimerWidth-1:0] HALF_LAST = SerialTimerWidth'((2**(SerialTimerWidth-1)) - 1);
  localparam logic [SerialTimerWidth-1:0] FULL_LAST = '1;
  localparam logic [IDX_W-1:0]            BIT_LAST  = IDX_W'(WordWidth - 1);
  localparam logic [AddressWidth-1:0]     SLOT_LAST = '1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  logic                        rx_meta_q, rxs_q;
  logic [2:0]                  state_q, state_d;
  logic [SerialTimerWidth-1:0] timer_q, timer_d;
  logic [IDX_W-1:0]            bit_idx_q, bit_idx_d;
  logic [WordWidth-1:0]        shift_q, shift_d;
  logic [AddressWidth-1:0]     cnt_q, cnt_d;
  logic [PKG_W-1:0]            buf_q, buf_d;
  logic [PKG_W-1:0]            data_q, data_d;
  logic                        valid_q, valid_d;
  logic                        error_q, error_d;
`ifdef SERIAL_RX_PACKAGE_TIMEOUT_EN
  localparam logic [SerialTimerWidth+3:0] IDLE_LAST = '1;
  logic [SerialTimerWidth+3:0] idle_q, idle_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
`ifdef SERIAL_RX_PACKAGE_TIMEOUT_EN
      idle_q    <= '0;
`endif
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
`ifdef SERIAL_RX_PACKAGE_TIMEOUT_EN
      idle_q    <= idle_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!rxs_q) state_d = ST_START;
      ST_START: if (timer_q == HALF_LAST) state_d = rxs_q ? ST_IDLE : ST_DATA;
      ST_DATA:  if (timer_q == FULL_LAST && bit_idx_q == BIT_LAST) state_d = ST_STOP;
      ST_STOP:  if (timer_q == FULL_LAST) state_d = rxs_q ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (rxs_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    timer_d   = timer_q + SerialTimerWidth'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      ST_IDLE: timer_d = '0;
      ST_START: begin
        if (timer_q == HALF_LAST) begin
          timer_d   = '0;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        // Timer wraps on its own, so each sample lands mid-bit.
        if (timer_q == FULL_LAST) begin
          shift_d   = {rxs_q, shift_q[WordWidth-1:1]};
          bit_idx_d = bit_idx_q + IDX_W'(1);
        end
      end
      ST_STOP: begin
        if (timer_q == FULL_LAST) begin
          if (rxs_q) begin
            buf_d[cnt_q*WordWidth +: WordWidth] = shift_q;
            if (cnt_q == SLOT_LAST) begin
              data_d  = buf_d;
              valid_d = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + AddressWidth'(1);
            end
          end else begin
            error_d = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      default: ;
    endcase
`ifdef SERIAL_RX_PACKAGE_TIMEOUT_EN
    idle_d = '0;
    if (state_q == ST_IDLE && rxs_q && cnt_q != '0) begin
      if (idle_q == IDLE_LAST) begin
        cnt_d   = '0;
        error_d = 1'b1;
      end else begin
        idle_d = idle_q + (SerialTimerWidth+4)'(1);
      end
    end
`endif
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign error = error_q;
  assign busy  = (state_q != ST_IDLE) || (cnt_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_serial_rx_package.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_rx_package
// Purpose  : Directed self-checking bench with a frame-level package model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_rx_package;

  localparam int P = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx  = 1'b1;
  logic [31:0] data;
  logic        valid, error, busy;

  int total = 0;
  int bad   = 0;

  logic [7:0]  m_words[$];
  logic [31:0] m_data = '0;
  logic [31:0] m_next = '0;
  bit          m_valid_due = 1'b0;
  bit          m_err_due   = 1'b0;

  always #5 clk = ~clk;

  serial_rx_package #(
    .AddressWidth    (2),
    .WordWidth       (8),
    .SerialTimerWidth(4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .data (data),
    .valid(valid),
    .error(error),
    .busy (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_data", data, 32'h0);
      check("rst_flags", {29'b0, valid, error, busy}, 32'h0);
    end else begin
      check("valid_error_excl", {31'b0, valid & error}, 32'h0);
      if (valid) begin
        check("valid_expected", {31'b0, m_valid_due}, 32'h1);
        check("pkg_data", data, m_next);
        m_data      = m_next;
        m_valid_due = 1'b0;
      end else begin
        check("data_stable", data, m_data);
      end
      if (error) begin
        check("error_expected", {31'b0, m_err_due}, 32'h1);
        m_err_due = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model outcome of a frame, recorded when its stop bit starts on the line.
  task automatic model_stop(input logic [7:0] b, input bit good);
    if (good) begin
      m_words.push_back(b);
      if (m_words.size() == 4) begin
        m_next      = {m_words[3], m_words[2], m_words[1], m_words[0]};
        m_valid_due = 1'b1;
        m_words.delete();
      end
    end else begin
      m_words.delete();
      m_err_due = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit good_stop);
    rx = 1'b0;
    tick(P);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(P);
    end
    model_stop(b, good_stop);
    rx = good_stop;
    tick(P);
    rx = 1'b1;
    check("valid_seen", {31'b0, m_valid_due}, 32'h0);
    check("error_seen", {31'b0, m_err_due}, 32'h0);
  endtask

  task automatic check_busy_idle(input string name);
    check(name, {31'b0, busy}, {31'b0, m_words.size() != 0});
  endtask

  initial begin
    // Reset with a toggling line
    for (int i = 0; i < 5; i++) begin
      rx = i[0];
      tick(1);
    end
    rx  = 1'b1;
    rst = 1'b1;
    tick(P);
    check("post_rst_busy", {31'b0, busy}, 32'h0);

    // Back-to-back package
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    send(8'h44, 1'b1);
    tick(4);
    check("pkg1_literal", data, 32'h44332211);
    check_busy_idle("busy_after_pkg1");

    // Framing error then clean package
    send(8'hA5, 1'b0);
    tick(P);
    check("data_held_after_err", data, 32'h44332211);
    check_busy_idle("busy_after_err");
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
    tick(4);
    check("pkg2_literal", data, 32'h04030201);

    // Short glitch
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(2 * P);
    check_busy_idle("busy_after_glitch");
    check("glitch_data", data, 32'h04030201);

    // Reset mid-package
    send(8'hDE, 1'b1);
    send(8'hAD, 1'b1);
    rx = 1'b0;
    tick(P);
    rx = 1'b1;
    tick(3 * P);
    rst = 1'b0;
    m_words.delete();
    m_data      = '0;
    m_valid_due = 1'b0;
    m_err_due   = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(P);
    check("busy_after_midrst", {31'b0, busy}, 32'h0);
    send(8'hAA, 1'b1);
    send(8'hBB, 1'b1);
    send(8'hCC, 1'b1);
    send(8'hDD, 1'b1);
    tick(4);
    check("pkg3_literal", data, 32'hDDCCBBAA);

    // Long idle with a partial package
    send(8'hB1, 1'b1);
    send(8'hB2, 1'b1);
`ifdef SERIAL_RX_PACKAGE_TIMEOUT_EN
    m_words.delete();
    m_err_due = 1'b1;
    tick(16 * P + 4);
    check("timeout_error_seen", {31'b0, m_err_due}, 32'h0);
    check("timeout_busy", {31'b0, busy}, 32'h0);
    send(8'h10, 1'b1);
    send(8'h20, 1'b1);
    send(8'h30, 1'b1);
    send(8'h40, 1'b1);
    tick(4);
    check("pkg4_literal", data, 32'h40302010);
    check_busy_idle("busy_end");
`else
    tick(16 * P + 4);
    check("hold_busy", {31'b0, busy}, 32'h1);
    send(8'h10, 1'b1);
    send(8'h20, 1'b1);
    send(8'h30, 1'b1);
    send(8'h40, 1'b1);
    tick(4);
    check("pkg4_literal", data, 32'h2010B2B1);
    check("busy_end", {31'b0, busy}, 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
